// File: rtl/sm_ifetch.sv
// Instruction fetch stage: owns the fetch PC, issues req/gnt word fetches and
// buffers in-order responses in a small queue presented to decode with PC and PC+8.
module sm_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus8,
  input  logic        instr_ready
);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   qword_q [QDEPTH];
  logic [31:0]   qpc_q   [QDEPTH];
  logic          grant, resp, push, pop;

  // Credits cover queued plus in-flight words, so the queue can never overflow.
  assign imem_req  = ~reset & ~redirect & (({1'b0, outst_q} + {1'b0, cnt_q}) < QD);
  assign imem_addr = fpc_q;

  assign grant = imem_req & imem_gnt;
  assign resp  = imem_rvalid & (outst_q != '0);
  assign push  = resp & (drop_q == '0) & ~redirect;
  assign pop   = instr_valid & instr_ready & ~redirect;

  assign instr_valid   = (cnt_q != '0);
  assign instr         = qword_q[head_q];
  assign instr_pc      = qpc_q[head_q];
  assign instr_pcplus8 = instr_pc + 32'd8;

  always_comb begin
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (redirect) begin
      fpc_d   = {redirect_pc[31:2], 2'b00};
      rpc_d   = {redirect_pc[31:2], 2'b00};
      // Every request still in flight after this cycle belongs to the old stream.
      outst_d = outst_q - CW'(resp);
      drop_d  = outst_q - CW'(resp);
      cnt_d   = '0;
      head_d  = tail_q;
    end else begin
      if (grant) fpc_d = fpc_q + 32'd4;
      outst_d = outst_q + CW'(grant) - CW'(resp);
      if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        rpc_d  = rpc_q + 32'd4;
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        qword_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) begin
        qword_q[tail_q] <= imem_rdata;
        qpc_q[tail_q]   <= rpc_q;
      end
    end
  end
endmodule
